// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and error responses.
// Optional DMEM_PERF_CNT_EN adds saturating load/store success counters.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3,
  parameter int AW      = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
`ifdef DMEM_PERF_CNT_EN
  output logic        busy_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
`else
  output logic        busy_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        go_resp;
  logic        accept;

  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;

  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_err;
  logic [AW-1:0] c_idx;
  logic        commit_wr;
  logic        commit_rd;

  logic [31:0] mem [DEPTH];

  assign busy_o = (state_q == WAIT);
  assign accept = req_i && (state_q != WAIT);

  // With LATENCY=1 the commit happens at the accepting edge, so the live inputs are used.
  assign c_we    = (state_q == WAIT) ? req_we_q    : we_i;
  assign c_addr  = (state_q == WAIT) ? req_addr_q  : addr_i;
  assign c_wdata = (state_q == WAIT) ? req_wdata_q : wdata_i;
  assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr >= 32'(4 * DEPTH));
  assign c_idx   = c_addr[AW+1:2];

  assign commit_wr = go_resp && c_we && !c_err;
  assign commit_rd = go_resp && !c_we && !c_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_we_q    <= we_i;
        req_addr_q  <= addr_i;
        req_wdata_q <= wdata_i;
      end
      ready_o <= go_resp;
      err_o   <= go_resp && c_err;
      if (commit_rd) rdata_o <= mem[c_idx];
    end
  end

  // Storage is deliberately not reset; a store caught by reset never commits.
  always_ff @(posedge clk_i) begin
    if (commit_wr && rst_i) mem[c_idx] <= c_wdata;
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_o <= 16'd0;
      wr_cnt_o <= 16'd0;
    end else begin
      if (commit_rd && rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
      if (commit_wr && wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=3 instance for handshake/error/reset cases and
// a LATENCY=1 instance for streaming (plus counters when DMEM_PERF_CNT_EN is set).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_err, a_busy, b_ready, b_err, b_busy;
`ifdef DMEM_PERF_CNT_EN
  logic [15:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(3), .AW(7)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wdata), .rdata_o(a_rdata),
    .ready_o(a_ready), .err_o(a_err),
`ifdef DMEM_PERF_CNT_EN
    .busy_o(a_busy), .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt)
`else
    .busy_o(a_busy)
`endif
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1), .AW(7)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wdata), .rdata_o(b_rdata),
    .ready_o(b_ready), .err_o(b_err),
`ifdef DMEM_PERF_CNT_EN
    .busy_o(b_busy), .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt)
`else
    .busy_o(b_busy)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // One full LATENCY=3 transaction on dut_a, entered and left 1ns after a rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    @(posedge clk); #1;
    a_req = 1'b0;
    checkOutput("busy_c1", {31'd0, a_busy}, 32'd1);
    checkOutput("ready_c1", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("busy_c2", {31'd0, a_busy}, 32'd1);
    checkOutput("ready_c2", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_c3", {31'd0, a_ready}, 32'd1);
    checkOutput("busy_c3", {31'd0, a_busy}, 32'd0);
    checkOutput("err_c3", {31'd0, a_err}, {31'd0, exp_err});
    checkOutput("rdata_c3", a_rdata, exp_rdata);
    @(posedge clk); #1;
    checkOutput("ready_c4", {31'd0, a_ready}, 32'd0);
    checkOutput("err_c4", {31'd0, a_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        bb_we   [4];
    logic [31:0] bb_addr [4];
    logic [31:0] bb_wdata[4];
    logic [31:0] bb_exp  [4];
    logic        s_we    [6];
    logic [31:0] s_addr  [6];
    logic [31:0] s_wdata [6];
    logic        s_err   [6];
    logic [31:0] s_exp   [6];

    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_ready", {31'd0, a_ready}, 32'd0);
    checkOutput("rst_err", {31'd0, a_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, a_busy}, 32'd0);
    checkOutput("rst_rdata", a_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic store/load, misaligned load, out-of-range store.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h40, 32'h1234, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 32'h1234);
    applyStimulus(1'b0, 32'h13, 32'h0, 1'b1, 32'h1234);
    applyStimulus(1'b1, 32'h1FC, 32'hA5A5A5A5, 1'b0, 32'h1234);
    applyStimulus(1'b1, 32'h200, 32'hFFFFFFFF, 1'b1, 32'h1234);
    applyStimulus(1'b0, 32'h1FC, 32'h0, 1'b0, 32'hA5A5A5A5);

    // Back-to-back with bogus requests held high while busy.
    bb_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
    bb_addr  = '{32'h0, 32'h0, 32'h4, 32'h4};
    bb_wdata = '{32'd1, 32'd0, 32'd2, 32'd0};
    bb_exp   = '{32'hA5A5A5A5, 32'd1, 32'd1, 32'd2};
    a_req = 1'b1; a_we = bb_we[0]; a_addr = bb_addr[0]; a_wdata = bb_wdata[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a_we = 1'b1; a_addr = 32'h0; a_wdata = 32'hBAD0BAD0;
      checkOutput($sformatf("bb%0d_busy1", i), {31'd0, a_busy}, 32'd1);
      checkOutput($sformatf("bb%0d_ready1", i), {31'd0, a_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("bb%0d_ready2", i), {31'd0, a_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("bb%0d_ready", i), {31'd0, a_ready}, 32'd1);
      checkOutput($sformatf("bb%0d_err", i), {31'd0, a_err}, 32'd0);
      checkOutput($sformatf("bb%0d_rdata", i), a_rdata, bb_exp[i]);
      if (i < 3) begin
        a_we = bb_we[i+1]; a_addr = bb_addr[i+1]; a_wdata = bb_wdata[i+1];
      end else begin
        a_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("bb_idle_ready", {31'd0, a_ready}, 32'd0);
    end

    // Reset aborts an in-flight store.
    applyStimulus(1'b1, 32'h20, 32'h55, 1'b0, 32'd2);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h99;
    @(posedge clk); #1;
    a_req = 1'b0;
    checkOutput("abort_busy", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", {31'd0, a_ready}, 32'd0);
    checkOutput("abort_busy0", {31'd0, a_busy}, 32'd0);
    checkOutput("abort_err", {31'd0, a_err}, 32'd0);
    checkOutput("abort_rdata", a_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_noready", {31'd0, a_ready}, 32'd0);
    end
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b0, 32'h55);

    // LATENCY=1 streaming on dut_b.
    s_we    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    s_addr  = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h8, 32'h3};
    s_wdata = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    s_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    s_exp   = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h33, 32'h33};
    b_req = 1'b1; b_we = s_we[0]; b_addr = s_addr[0]; b_wdata = s_wdata[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("l1_%0d_ready", i), {31'd0, b_ready}, 32'd1);
      checkOutput($sformatf("l1_%0d_err", i), {31'd0, b_err}, {31'd0, s_err[i]});
      checkOutput($sformatf("l1_%0d_rdata", i), b_rdata, s_exp[i]);
      checkOutput($sformatf("l1_%0d_busy", i), {31'd0, b_busy}, 32'd0);
      if (i < 5) begin
        b_we = s_we[i+1]; b_addr = s_addr[i+1]; b_wdata = s_wdata[i+1];
      end else begin
        b_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput("l1_idle_ready", {31'd0, b_ready}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("l1_wr_cnt", {16'd0, b_wr_cnt}, 32'd3);
    checkOutput("l1_rd_cnt", {16'd0, b_rd_cnt}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
